// File: rtl/clock_sequencer_bank_if.sv
// clock_sequencer_bank_if: control and output bundle of the
// N-channel clock sequencer.
interface clock_sequencer_bank_if #(
  parameter int NCH   = 2,
  parameter int DIV_W = 4,
  parameter int DLY_W = 8
);
  logic                   sync_n;
  logic                   arm;
  logic                   stop;
  logic [DLY_W-1:0]       start_dly;
  logic [NCH*DIV_W-1:0]   div_i;
  logic [NCH*DIV_W-1:0]   phase_i;
  logic [NCH*DLY_W-1:0]   rel_dly;
  logic [NCH-1:0]         clk_o;
  logic [NCH-1:0]         tick_o;
  logic [NCH-1:0]         rst_o;
  logic                   running;
  logic [1:0]             state_o;

  modport master (
    output sync_n, arm, stop,
    output start_dly, div_i,
    output phase_i, rel_dly,
    input  clk_o, tick_o, rst_o,
    input  running, state_o
  );

  modport slave (
    input  sync_n, arm, stop,
    input  start_dly, div_i,
    input  phase_i, rel_dly,
    output clk_o, tick_o, rst_o,
    output running, state_o
  );
endinterface

// File: rtl/clock_sequencer_bank.sv
// clock_sequencer_bank: N-channel integer clock divider with a
// sync-aligned start and staged per-channel reset release.
module clock_sequencer_bank #(
  parameter int NCH   = 2,
  parameter int DIV_W = 4,
  parameter int DLY_W = 8
) (
  input logic                   clkin,
  input logic                   reset,
  clock_sequencer_bank_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t           state;
  logic             running_q;
  logic [2:0]       sync_q;
  logic             sync_ev;
  logic             enter;
  logic [DLY_W-1:0] dly_cnt;
  logic [DLY_W-1:0] rel_cnt;
  logic [NCH-1:0]   clk_q;
  logic [NCH-1:0]   tick_q;
  logic [NCH-1:0]   rst_q;
  logic [DIV_W-1:0] div_cur [NCH];
  logic [DIV_W-1:0] cnt     [NCH];
  logic [DIV_W-1:0] div_new [NCH];
  logic [DIV_W-1:0] ph_new  [NCH];

  function automatic logic [DIV_W-1:0] eff_div(
    input logic [DIV_W-1:0] d
  );
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  // sync_q[1] is the synchronised pin, sync_q[2] its last value
  assign sync_ev = sync_q[2] & ~sync_q[1];
  assign enter   = (state == DELAY) &&
                   (dly_cnt == bus.start_dly) &&
                   !bus.stop;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[1:0], bus.sync_n};
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dly_cnt   <= '0;
      running_q <= 1'b0;
    end else if (bus.stop) begin
      state     <= IDLE;
      dly_cnt   <= '0;
      running_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE:  if (bus.arm) state <= ARMED;
        ARMED: if (sync_ev) begin
          state   <= DELAY;
          dly_cnt <= '0;
        end
        DELAY: if (enter) begin
          state     <= RUN;
          running_q <= 1'b1;
        end else begin
          dly_cnt <= dly_cnt + 1'b1;
        end
        RUN: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      div_new[i] = eff_div(bus.div_i[i*DIV_W +: DIV_W]);
      ph_new[i]  = bus.phase_i[i*DIV_W +: DIV_W];
      if (ph_new[i] > div_new[i] - 1'b1)
        ph_new[i] = div_new[i] - 1'b1;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      rel_cnt <= '0;
      clk_q   <= '0;
      tick_q  <= '0;
      rst_q   <= '1;
      for (int i = 0; i < NCH; i++) begin
        div_cur[i] <= '0;
        cnt[i]     <= '0;
      end
    end else if (enter) begin
      rel_cnt <= '0;
      clk_q   <= '0;
      tick_q  <= '0;
      rst_q   <= '1;
      for (int i = 0; i < NCH; i++) begin
        div_cur[i] <= div_new[i];
        cnt[i]     <= ph_new[i];
      end
    end else if (state == RUN && !bus.stop) begin
      if (rel_cnt != '1) rel_cnt <= rel_cnt + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        clk_q[i]  <= cnt[i] >= (div_cur[i] >> 1);
        tick_q[i] <= cnt[i] == (div_cur[i] >> 1);
        if (bus.rel_dly[i*DLY_W +: DLY_W] == rel_cnt)
          rst_q[i] <= 1'b0;
        // new divisor only lands on a period boundary
        if (cnt[i] == div_cur[i] - 1'b1) begin
          cnt[i]     <= '0;
          div_cur[i] <= div_new[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end else begin
      rel_cnt <= '0;
      clk_q   <= '0;
      tick_q  <= '0;
      rst_q   <= '1;
      for (int i = 0; i < NCH; i++)
        cnt[i] <= '0;
    end
  end

  assign bus.clk_o   = clk_q;
  assign bus.tick_o  = tick_q;
  assign bus.rst_o   = rst_q;
  assign bus.running = running_q;
  assign bus.state_o = state;
endmodule

// File: tb/tb_clock_sequencer_bank.sv
// tb_clock_sequencer_bank: randomized and directed checks of the
// clock sequencer against closed-form waveform expectations.
module tb_clock_sequencer_bank;
  localparam int NCH   = 2;
  localparam int DIV_W = 4;
  localparam int DLY_W = 8;

  logic clkin = 1'b0;
  logic reset = 1'b1;
  always #5 clkin = ~clkin;

  clock_sequencer_bank_if #(
    .NCH(NCH), .DIV_W(DIV_W), .DLY_W(DLY_W)
  ) bus ();

  clock_sequencer_bank #(
    .NCH(NCH), .DIV_W(DIV_W), .DLY_W(DLY_W)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int lat;
  logic [1:0] rc [0:1023];
  logic [1:0] rt [0:1023];
  logic [1:0] rr [0:1023];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int effd(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic logic [31:0] outs();
    return {23'd0, bus.state_o, bus.running,
            bus.clk_o, bus.tick_o, bus.rst_o};
  endfunction

  // Arm, sync, record nc RUN cycles, compare, then stop.
  // kc >= 0 switches ch0 divisor to nd0 during RUN cycle kc.
  task automatic run_case(input string tag,
                          input int d0, input int d1,
                          input int p0, input int p1,
                          input int sd,
                          input int r0, input int r1,
                          input int nc, input int kc,
                          input int nd0);
    int dv [2];
    int ph [2];
    int rd [2];
    int cnt, len, nd;
    logic eclk, etick;
    logic [2:0] got, exp;
    dv[0] = d0; dv[1] = d1;
    ph[0] = p0; ph[1] = p1;
    rd[0] = r0; rd[1] = r1;
    @(negedge clkin);
    bus.div_i     = {4'(d1), 4'(d0)};
    bus.phase_i   = {4'(p1), 4'(p0)};
    bus.rel_dly   = {8'(r1), 8'(r0)};
    bus.start_dly = 8'(sd);
    bus.arm = 1'b1;
    @(negedge clkin);
    bus.arm = 1'b0;
    chk($sformatf("%s armed", tag), 32'(bus.state_o), 1);
    bus.sync_n = 1'b0;
    lat = 0;
    while (!bus.running && lat < 300) begin
      @(negedge clkin);
      lat++;
    end
    chk($sformatf("%s start latency", tag), lat, sd + 4);
    bus.sync_n = 1'b1;
    if (bus.running) begin
      for (int k = 0; k < nc; k++) begin
        rc[k] = bus.clk_o;
        rt[k] = bus.tick_o;
        rr[k] = bus.rst_o;
        if (k == kc) bus.div_i[3:0] = 4'(nd0);
        @(negedge clkin);
      end
      for (int i = 0; i < 2; i++) begin
        len   = effd(dv[i]);
        cnt   = (ph[i] < len - 1) ? ph[i] : len - 1;
        eclk  = 1'b0;
        etick = 1'b0;
        for (int k = 0; k < nc; k++) begin
          got = {rc[k][i], rt[k][i], rr[k][i]};
          exp = {eclk, etick, 1'(k <= rd[i])};
          chk($sformatf("%s ch%0d cyc%0d", tag, i, k),
              32'(got), 32'(exp));
          eclk  = cnt >= len / 2;
          etick = cnt == len / 2;
          nd = (i == 0 && kc >= 0 && k >= kc) ? nd0 : dv[i];
          if (cnt == len - 1) begin
            cnt = 0;
            len = effd(nd);
          end else begin
            cnt++;
          end
        end
      end
    end
    bus.stop = 1'b1;
    @(negedge clkin);
    bus.stop = 1'b0;
    chk($sformatf("%s stop", tag), outs(), 32'h3);
  endtask

  initial begin
    int bad;
    bus.sync_n    = 1'b1;
    bus.arm       = 1'b0;
    bus.stop      = 1'b0;
    bus.start_dly = '0;
    bus.div_i     = '0;
    bus.phase_i   = '0;
    bus.rel_dly   = '0;
    repeat (3) @(negedge clkin);
    chk("reset values", outs(), 32'h3);
    reset = 1'b0;
    @(negedge clkin);
    chk("post reset idle", outs(), 32'h3);

    run_case("div7_8", 7, 8, 0, 0, 3, 12, 20, 120, -1, 0);
    run_case("phase_lead", 8, 8, 0, 3, 1, 5, 5, 820, -1, 0);
    bad = 0;
    for (int k = 1; k < 816; k++)
      if (rc[k][1] !== rc[k+3][0]) bad++;
    chk("phase lead 3", bad, 0);
    run_case("divchg", 7, 5, 0, 0, 0, 3, 4, 60, 10, 8);
    run_case("div0_1", 0, 1, 0, 1, 2, 0, 1, 40, -1, 0);
    run_case("phase9", 8, 3, 9, 9, 5, 7, 2, 40, -1, 0);

    for (int s = 0; s < 12; s++)
      run_case($sformatf("rnd%0d", s),
               int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)),
               int'($urandom_range(0, 12)),
               int'($urandom_range(0, 60)),
               int'($urandom_range(0, 60)),
               100,
               int'($urandom_range(5, 60)),
               int'($urandom_range(0, 15)));

    // sync while idle is ignored, armed waits for a fresh event
    @(negedge clkin);
    bus.start_dly = 8'd4;
    bus.sync_n = 1'b0;
    repeat (4) @(negedge clkin);
    bus.sync_n = 1'b1;
    repeat (4) @(negedge clkin);
    chk("idle ignores sync", 32'(bus.state_o), 0);
    bus.arm = 1'b1;
    @(negedge clkin);
    bus.arm = 1'b0;
    repeat (10) @(negedge clkin);
    chk("armed holds", 32'(bus.state_o), 1);
    bus.sync_n = 1'b0;
    repeat (3) @(negedge clkin);
    chk("later sync delay", 32'(bus.state_o), 2);
    bus.stop = 1'b1;
    @(negedge clkin);
    bus.stop = 1'b0;
    bus.sync_n = 1'b1;
    chk("stop in delay", 32'(bus.state_o), 0);
    bus.arm = 1'b1;
    bus.stop = 1'b1;
    @(negedge clkin);
    bus.stop = 1'b0;
    @(negedge clkin);
    bus.arm = 1'b0;
    chk("arm then arm+stop", 32'(bus.state_o), 1);
    bus.arm = 1'b1;
    bus.stop = 1'b1;
    @(negedge clkin);
    bus.arm = 1'b0;
    bus.stop = 1'b0;
    chk("arm+stop armed", 32'(bus.state_o), 0);

    // async reset mid-run
    repeat (3) @(negedge clkin);
    bus.div_i     = {4'd8, 4'd8};
    bus.phase_i   = '0;
    bus.rel_dly   = {8'd5, 8'd5};
    bus.start_dly = 8'd0;
    bus.arm = 1'b1;
    @(negedge clkin);
    bus.arm = 1'b0;
    bus.sync_n = 1'b0;
    lat = 0;
    while (!bus.running && lat < 50) begin
      @(negedge clkin);
      lat++;
    end
    repeat (30) @(negedge clkin);
    chk("pre-reset run", outs(), {23'd0, 2'd3, 1'b1,
                                  bus.clk_o, bus.tick_o, 2'b00});
    #2 reset = 1'b1;
    #1 chk("async reset", outs(), 32'h3);
    @(negedge clkin);
    reset = 1'b0;
    bus.sync_n = 1'b1;
    @(negedge clkin);
    chk("after reset idle", outs(), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
